// File: rtl/dbg_bridge_pkg.sv
// Shared types and defaults for the Nios II debug-slave sysclk bridge.
// Holds the command FSM state enum and the action-flag bit helper.
package dbg_bridge_pkg;

  localparam int SR_W_DEF        = 38;
  localparam int IR_W_DEF        = 2;
  localparam int SYNC_STAGES_DEF = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  // The scan register MSB selects take_action over take_no_action.
  function automatic int action_bit(input int sr_w);
    return sr_w - 1;
  endfunction

endpackage

// File: rtl/dbg_tgl_sync.sv
// TCK-domain toggle to one-cycle sysclk pulse; STAGES cycles from toggle edge to pulse.
// No backpressure: each toggle edge yields exactly one pulse.
module dbg_tgl_sync #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tgl_i,
  output logic pulse_o
);

  localparam int S = (STAGES < 2) ? 2 : STAGES;

  logic [S-1:0] sync_q;
  logic         pulse_q;

  // Registering the edge detect keeps the pulse glitch-free for the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[S-2:0], tgl_i};
      pulse_q <= sync_q[S-1] ^ sync_q[S-2];
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/dbg_cmd_sysclk_bridge.sv
// Sysclk half of the JTAG debug slave: latches scanned commands, valid/ready to the OCI, then one-hot strobes.
// cmd_valid rises SYNC_STAGES+1 cycles after udr_tgl; optional DBG_SR_PARITY_EN adds sr_par/par_err.
module dbg_cmd_sysclk_bridge
  import dbg_bridge_pkg::*;
#(
  parameter  int SR_W        = SR_W_DEF,
  parameter  int IR_W        = IR_W_DEF,
  parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter  int ACK_TO      = 255,
  localparam int NUM_CMD     = 2 ** IR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               udr_tgl,
  input  logic               uir_tgl,
  input  logic [IR_W-1:0]    ir_in,
  input  logic [SR_W-1:0]    sr_in,
  output logic [SR_W-1:0]    jdo,
  output logic [IR_W-1:0]    cmd_ir,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [NUM_CMD-1:0] take_action,
  output logic [NUM_CMD-1:0] take_no_action,
  output logic [IR_W-1:0]    ir_latched,
  input  logic               clr_status,
`ifdef DBG_SR_PARITY_EN
  input  logic               sr_par,
  output logic               par_err,
`endif
  output logic               overrun,
  output logic               timeout
);

  localparam int              ACT_BIT = action_bit(SR_W);
  localparam int              CNT_W   = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((ACK_TO > 0) ? ACK_TO - 1 : 0);

  logic udr_evt;
  logic uir_evt;

  dbg_tgl_sync #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset   (reset),
    .tgl_i   (udr_tgl),
    .pulse_o (udr_evt)
  );

  dbg_tgl_sync #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset   (reset),
    .tgl_i   (uir_tgl),
    .pulse_o (uir_evt)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   jdo_q;
  logic [IR_W-1:0]   cmd_ir_q;
  logic [IR_W-1:0]   ir_lat_q;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic hs;
  logic to_hit;
  logic par_ok;
  logic slot_free;
  logic capture;

`ifdef DBG_SR_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_ok = ^{sr_in, sr_par};
`else
  assign par_ok = 1'b1;
`endif

  // A handshake frees the slot in the same cycle, so a coincident Update-DR is accepted.
  assign hs        = (state_q == PEND) && cmd_ready;
  assign to_hit    = (ACK_TO != 0) && (state_q == PEND) && !cmd_ready && (cnt_q == TO_LAST);
  assign slot_free = (state_q == IDLE) || hs;
  assign capture   = udr_evt && par_ok && slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture) state_d = PEND;
      end
      PEND: begin
        if (hs)          state_d = capture ? PEND : IDLE;
        else if (to_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (hs) begin
      if (jdo_q[ACT_BIT]) take_action[cmd_ir_q]    = 1'b1;
      else                take_no_action[cmd_ir_q] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (!capture && (state_q == PEND)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Sticky flags: a same-cycle set beats clr_status.
  assign overrun_d = (clr_status ? 1'b0 : overrun_q)
                   | ((state_q == PEND) && udr_evt && !cmd_ready);
  assign timeout_d = (clr_status ? 1'b0 : timeout_q) | to_hit;
`ifdef DBG_SR_PARITY_EN
  assign par_err_d = (clr_status ? 1'b0 : par_err_q) | (udr_evt && !par_ok && slot_free);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      jdo_q     <= '0;
      cmd_ir_q  <= '0;
      ir_lat_q  <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      if (capture) begin
        jdo_q    <= sr_in;
        cmd_ir_q <= ir_in;
      end
      if (uir_evt) ir_lat_q <= ir_in;
    end
  end

`ifdef DBG_SR_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end
  assign par_err = par_err_q;
`endif

  assign jdo        = jdo_q;
  assign cmd_ir     = cmd_ir_q;
  assign cmd_valid  = (state_q == PEND);
  assign ir_latched = ir_lat_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/dbg_cmd_sysclk_bridge.md
Name: dbg_cmd_sysclk_bridge

Overview:
Parametrised system-clock half of the Nios II JTAG debug slave.
- Receives the TCK-domain scan register and IR, which are quasi-static, together with Update-DR and Update-IR toggle events.
- Synchronises the toggles and latches each scanned command.
- Presents the command to the OCI core through a valid/ready handshake, then issues one-hot take_action / take_no_action strobes per IR code.
- Successor to the fixed 38-bit/2-bit sysclk bridge. Adds configurable width, IR size, synchroniser depth, back-pressure, overrun detection and a handshake timeout.

Parameters:
SR_W, 38, scan register / jdo width; bit SR_W-1 is the action flag
IR_W, 2, IR width; NUM_CMD = 2**IR_W strobe channels
SYNC_STAGES, 3, synchroniser flops on each toggle input (minimum 2)
ACK_TO, 255, cycles cmd_valid may wait for cmd_ready before the command is dropped; 0 disables the timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
udr_tgl  in  1  toggles once per Update-DR (TCK domain)
uir_tgl  in  1  toggles once per Update-IR (TCK domain)
ir_in  in  IR_W  IR value, stable around udr_tgl
sr_in  in  SR_W  scan register, stable around udr_tgl
jdo  out  SR_W  latched command data
cmd_ir  out  IR_W  IR of the latched command
cmd_valid  out  1  command pending
cmd_ready  in  1  consumer accepts the command
take_action  out  NUM_CMD  one-cycle strobe, indexed by cmd_ir, when the action flag is 1
take_no_action  out  NUM_CMD  one-cycle strobe, indexed by cmd_ir, when the action flag is 0
ir_latched  out  IR_W  IR captured on the last Update-IR
clr_status  in  1  clears the sticky flags
overrun  out  1  sticky: Update-DR arrived while a command was pending
timeout  out  1  sticky: a command was dropped on ACK_TO

Behaviour:
- Reset: all of the following are 0 — jdo, cmd_ir, cmd_valid, take_action, take_no_action, ir_latched, overrun, timeout, the timeout counter, and every synchroniser flop.
- Synchronisation:
  - Each toggle passes through a SYNC_STAGES flop chain.
  - An event is the XOR of the last two stages, giving a one-cycle pulse.
  - Latency from a toggle change to the event is SYNC_STAGES cycles.
- FSM states: IDLE, PEND.
  - IDLE + udr_evt: jdo<=sr_in, cmd_ir<=ir_in, cmd_valid<=1 on the next cycle; go to PEND.
  - PEND + cmd_ready (handshake cycle): cmd_valid<=0 next cycle.
    - In that same handshake cycle, take_action[cmd_ir] or take_no_action[cmd_ir] is driven for exactly one cycle, selected by jdo[SR_W-1].
    - The strobe is combinational from registered state and is never asserted outside a handshake.
    - Go to IDLE.
  - PEND + udr_evt without cmd_ready: the new command is discarded, overrun<=1, the pending command is unchanged.
  - PEND + udr_evt + cmd_ready in the same cycle: the handshake completes, the new command is latched, stay in PEND, no overrun.
  - PEND, counter reaches ACK_TO with no cmd_ready: cmd_valid<=0, timeout<=1, no strobe, go to IDLE. The counter clears whenever PEND is entered.
- Stability: jdo and cmd_ir are stable for the whole time cmd_valid is high.
- uir_evt: ir_latched<=ir_in in any state; the pending command is unaffected.
- clr_status clears both sticky flags. A same-cycle set wins over the clear.
- Reset asserted mid-PEND: the command is lost and no strobe is issued.

Optional Feature:
DBG_SR_PARITY_EN
- With the macro: adds input sr_par (1 bit) and sticky output par_err.
  - At capture, odd parity over {sr_in, sr_par} is checked.
  - On mismatch the command is discarded (stay in IDLE) and par_err<=1.
  - par_err is cleared by clr_status.
- Without the macro: neither port exists and every capture is accepted.

Decomposition:
- Package dbg_bridge_pkg holds:
  - the state enum {IDLE, PEND}
  - the default SR_W, IR_W and SYNC_STAGES constants
  - the ACTION_BIT index function (SR_W-1)
- One sub-module, dbg_tgl_sync: a parametrised SYNC_STAGES flop chain with toggle-to-pulse output. It is instantiated twice, for udr and uir.

Test Plan:
- Reset, then udr_tgl flip with sr_in MSB=1, ir_in=2, cmd_ready=1 -> cmd_valid rises SYNC_STAGES+1 cycles later; take_action=4'b0100 for exactly 1 cycle; jdo=sr_in.
- Same as above with MSB=0, ir_in=0 -> take_no_action=4'b0001; take_action stays 0.
- cmd_ready held 0, second udr_tgl flip -> overrun=1; jdo keeps the first value; releasing cmd_ready gives one strobe for the first command only.
- ACK_TO=4, cmd_ready never asserted -> cmd_valid drops after 4 PEND cycles; timeout=1; no strobe; clr_status clears the flag.
- udr_evt coincident with the cmd_ready handshake -> first command strobed, second latched, overrun stays 0; uir_tgl flip with ir_in=3 -> ir_latched=3 while PEND is untouched.
- DBG_SR_PARITY_EN build with wrong sr_par -> cmd_valid stays 0 and par_err=1; reset mid-PEND -> all outputs 0 and no strobe.
